// File: rtl/bit_stream_pkg.sv
// Shared types and constants for the sync-hunt / deframe datapath.
package bit_stream_pkg;

    // Deframer control states: hunting for lock, collecting payload, sampling parity.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1,
        PARITY  = 2'd2
    } deframe_state_t;

    // Sync word the upstream detector hunts for; the deframer only sees its lock pulse.
    localparam int                      SYNC_LEN     = 7;
    localparam logic [SYNC_LEN-1:0]     SYNC_PATTERN = 7'b1001001;

endpackage : bit_stream_pkg

// File: rtl/bit_deser.sv
// Serial-to-parallel word assembler: MSB-first shift register with a bit counter.
// word/word_done are combinational so the owner can capture the complete word,
// including the bit being sampled, on the same edge that samples it.
module bit_deser
    import bit_stream_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              din,
    input  logic              shift_en,
    input  logic              clr,
    output logic [DATA_W-1:0] word,
    output logic              word_done
);

    localparam int BC_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    logic [DATA_W-1:0] r_sr;
    logic [BC_W-1:0]   r_bit_cnt;
    logic [DATA_W-1:0] w_word;
    logic              w_last_bit;

    // Next shift-register contents: current bits move up, din lands in the LSB.
    assign w_word     = DATA_W'({r_sr, din});
    assign w_last_bit = (r_bit_cnt == BC_W'(DATA_W - 1));

    assign word      = w_word;
    assign word_done = shift_en & w_last_bit;

    // Shift one bit per enabled edge; the counter wraps after the last bit of a word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sr      <= '0;
            r_bit_cnt <= '0;
        end else if (clr) begin
            r_sr      <= '0;
            r_bit_cnt <= '0;
        end else if (shift_en) begin
            r_sr      <= w_word;
            r_bit_cnt <= w_last_bit ? '0 : r_bit_cnt + BC_W'(1);
        end
    end

endmodule : bit_deser

// File: rtl/bit_stream_deframer.sv
// Deframer that follows the sync detector: after a lock pulse it collects
// FRAME_WORDS payload words MSB-first, checks a trailing even-parity bit,
// reports frame status and returns to waiting for the next lock.
module bit_stream_deframer
    import bit_stream_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int FRAME_WORDS = 4,
    parameter int CNT_W       = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              din,
    input  logic              lock,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic [CNT_W-1:0]  word_cnt,
    output logic              frame_active,
    output logic              frame_done,
    output logic              parity_err
);

    deframe_state_t    r_state;
    logic [DATA_W-1:0] r_data_out;
    logic              r_data_valid;
    logic [CNT_W-1:0]  r_word_cnt;
    logic              r_frame_active;
    logic              r_frame_done;
    logic              r_parity_err;
    logic              r_parity_acc;

    logic              w_shift_en;
    logic              w_clr;
    logic [DATA_W-1:0] w_word;
    logic              w_word_done;
    logic              w_last_word;

    // The deserialiser shifts only during payload and is held clear while hunting,
    // so a new frame always starts from bit 0 of word 0.
    assign w_shift_en  = (r_state == PAYLOAD);
    assign w_clr       = (r_state == IDLE);
    assign w_last_word = (r_word_cnt == CNT_W'(FRAME_WORDS - 1));

    bit_deser #(
        .DATA_W   (DATA_W)
    ) u_deser (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .shift_en  (w_shift_en),
        .clr       (w_clr),
        .word      (w_word),
        .word_done (w_word_done)
    );

    // Frame FSM with registered outputs; lock is ignored outside IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_data_out     <= '0;
            r_data_valid   <= 1'b0;
            r_word_cnt     <= '0;
            r_frame_active <= 1'b0;
            r_frame_done   <= 1'b0;
            r_parity_err   <= 1'b0;
            r_parity_acc   <= 1'b0;
        end else begin
            r_data_valid <= 1'b0;
            r_frame_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    // din on the lock edge is the final sync bit, not payload.
                    if (lock) begin
                        r_state        <= PAYLOAD;
                        r_word_cnt     <= '0;
                        r_parity_acc   <= 1'b0;
                        r_frame_active <= 1'b1;
                    end
                end
                PAYLOAD: begin
                    r_parity_acc <= r_parity_acc ^ din;
                    if (w_word_done) begin
                        r_data_out   <= w_word;
                        r_data_valid <= 1'b1;
                        r_word_cnt   <= r_word_cnt + CNT_W'(1);
                        if (w_last_word) begin
                            r_state <= PARITY;
                        end
                    end
                end
                PARITY: begin
                    // Odd total of ones over payload plus parity bit is an error.
                    r_parity_err   <= r_parity_acc ^ din;
                    r_frame_done   <= 1'b1;
                    r_frame_active <= 1'b0;
                    r_state        <= IDLE;
                end
                default: begin
                    r_state        <= IDLE;
                    r_frame_active <= 1'b0;
                end
            endcase
        end
    end

    assign data_out     = r_data_out;
    assign data_valid   = r_data_valid;
    assign word_cnt     = r_word_cnt;
    assign frame_active = r_frame_active;
    assign frame_done   = r_frame_done;
    assign parity_err   = r_parity_err;

endmodule : bit_stream_deframer

// File: tb/tb_bit_stream_deframer.sv
// Bench for bit_stream_deframer: directed frames plus randomized traffic,
// checked every cycle against a bit-list model of the frame format.
module tb_bit_stream_deframer;
    import bit_stream_pkg::*;

    localparam int DATA_W = 8;
    localparam int FW     = 4;
    localparam int CNT_W  = 8;
    localparam int NBITS  = DATA_W * FW;

    logic              clk;
    logic              rst_n;
    logic              din;
    logic              lock;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic [CNT_W-1:0]  word_cnt;
    logic              frame_active;
    logic              frame_done;
    logic              parity_err;

    bit_stream_deframer #(
        .DATA_W      (DATA_W),
        .FRAME_WORDS (FW),
        .CNT_W       (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .din          (din),
        .lock         (lock),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .word_cnt     (word_cnt),
        .frame_active (frame_active),
        .frame_done   (frame_done),
        .parity_err   (parity_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total;
    int bad;
    int edge_cnt;
    int lock_edge;

    // Model: list of bits received since lock, and the outputs they imply.
    bit          m_active;
    int          m_pos;
    bit          m_bits [0:NBITS];
    logic [7:0]  e_data_out;
    bit          e_valid;
    int          e_cnt;
    bit          e_active;
    bit          e_done;
    bit          e_perr;
    logic [7:0]  mq_words [$];

    // Observed DUT events for the literal checks.
    logic [7:0]  cap_words [$];
    int          cap_done_n;
    int          cap_lat;
    bit          cap_perr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active   = 1'b0;
        m_pos      = 0;
        e_data_out = '0;
        e_valid    = 1'b0;
        e_cnt      = 0;
        e_active   = 1'b0;
        e_done     = 1'b0;
        e_perr     = 1'b0;
    endtask

    task automatic model_edge(input bit d, input bit l);
        int ones;
        logic [7:0] w;
        e_valid = 1'b0;
        e_done  = 1'b0;
        if (!m_active) begin
            if (l) begin
                m_active  = 1'b1;
                m_pos     = 0;
                e_cnt     = 0;
                e_active  = 1'b1;
                lock_edge = edge_cnt;
            end
        end else begin
            m_bits[m_pos] = d;
            m_pos++;
            if (m_pos <= NBITS && (m_pos % DATA_W) == 0) begin
                w = '0;
                for (int j = 0; j < DATA_W; j++) w = {w[6:0], m_bits[m_pos - DATA_W + j]};
                e_data_out = w;
                e_valid    = 1'b1;
                e_cnt      = m_pos / DATA_W;
                mq_words.push_back(w);
            end else if (m_pos == NBITS + 1) begin
                ones = 0;
                for (int j = 0; j <= NBITS; j++) ones += int'(m_bits[j]);
                e_perr   = (ones % 2) == 1;
                e_done   = 1'b1;
                e_active = 1'b0;
                m_active = 1'b0;
            end
        end
    endtask

    // One clock: present inputs, let the edge happen, advance the model.
    task automatic step(input bit d, input bit l);
        din  = d;
        lock = l;
        @(posedge clk);
        edge_cnt++;
        if (!rst_n) model_reset();
        else        model_edge(d, l);
        #2;
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            chk("data_out",     32'(data_out),     32'(e_data_out));
            chk("data_valid",   32'(data_valid),   32'(e_valid));
            chk("word_cnt",     32'(word_cnt),     32'(e_cnt));
            chk("frame_active", 32'(frame_active), 32'(e_active));
            chk("frame_done",   32'(frame_done),   32'(e_done));
            chk("parity_err",   32'(parity_err),   32'(e_perr));
            if (data_valid) cap_words.push_back(data_out);
            if (frame_done) begin
                cap_done_n++;
                cap_lat  = edge_cnt - lock_edge;
                cap_perr = parity_err;
            end
        end
    endtask

    task automatic clear_caps();
        cap_words.delete();
        mq_words.delete();
        cap_done_n = 0;
        cap_lat    = -1;
    endtask

    // Lock edge, NBITS payload bits (optional spurious lock at bit xlock), parity bit.
    task automatic send_frame(input logic [31:0] wds, input bit par, input int xlock);
        step(1'($urandom_range(0, 1)), 1'b1);
        for (int i = 0; i < NBITS; i++) step(wds[31 - i], (i == xlock));
        step(par, 1'b0);
    endtask

    task automatic check_words(input string nm, input logic [31:0] wds);
        chk({nm, "_ndut"}, 32'(cap_words.size()), 32'd4);
        chk({nm, "_nmod"}, 32'(mq_words.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < cap_words.size()) chk({nm, "_dut_word"}, 32'(cap_words[i]), 32'(wds[31 - 8*i -: 8]));
            if (i < mq_words.size())  chk({nm, "_mod_word"}, 32'(mq_words[i]),  32'(wds[31 - 8*i -: 8]));
        end
    endtask

    initial begin
        logic [31:0] rw;
        bit          rbad;
        int          rx;
        total    = 0;
        bad      = 0;
        edge_cnt = 0;
        lock_edge = 0;
        rst_n    = 1'b0;
        din      = 1'b0;
        lock     = 1'b0;
        model_reset();
        clear_caps();
        fork
            compare_loop();
        join_none

        // Reset, then idle with din=0, lock=0.
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0);
        chk("idle_active", 32'(frame_active), 32'd0);
        chk("idle_wcnt",   32'(word_cnt),     32'd0);

        // Nominal frame: A5 3C FF 01, 17 payload ones, parity bit 1.
        clear_caps();
        send_frame(32'hA53CFF01, 1'b1, -1);
        step(1'b0, 1'b0);
        check_words("nominal", 32'hA53CFF01);
        chk("nominal_done_n", 32'(cap_done_n), 32'd1);
        chk("nominal_latency", 32'(cap_lat), 32'd33);
        chk("nominal_perr", 32'(cap_perr), 32'd0);
        chk("nominal_wcnt_hold", 32'(word_cnt), 32'd4);

        // Bad parity: same payload, parity bit 0; error sticks while idle.
        clear_caps();
        send_frame(32'hA53CFF01, 1'b0, -1);
        for (int i = 0; i < 6; i++) step(1'($urandom_range(0, 1)), 1'b0);
        chk("badpar_perr", 32'(cap_perr), 32'd1);
        chk("badpar_hold", 32'(parity_err), 32'd1);

        // Spurious lock after 5 bits of word 0 is ignored.
        clear_caps();
        send_frame(32'hA53CFF01, 1'b1, 5);
        step(1'b0, 1'b0);
        check_words("midlock", 32'hA53CFF01);
        chk("midlock_latency", 32'(cap_lat), 32'd33);

        // Back-to-back: second lock on the edge closing the frame_done cycle.
        clear_caps();
        send_frame(32'hA53CFF01, 1'b0, -1);
        send_frame(32'h00000000, 1'b0, -1);
        step(1'b0, 1'b0);
        chk("b2b_done_n", 32'(cap_done_n), 32'd2);
        chk("b2b_nwords", 32'(cap_words.size()), 32'd8);
        if (cap_words.size() == 8) chk("b2b_last_word", 32'(cap_words[7]), 32'd0);
        chk("b2b_perr", 32'(cap_perr), 32'd0);

        // Reset in the middle of word 2, then a fresh frame.
        clear_caps();
        step(1'b0, 1'b1);
        for (int i = 0; i < 12; i++) step(1'($urandom_range(0, 1)), 1'b0);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_async_active", 32'(frame_active), 32'd0);
        chk("rst_async_wcnt",   32'(word_cnt),     32'd0);
        chk("rst_async_data",   32'(data_out),     32'd0);
        for (int i = 0; i < 3; i++) step(1'($urandom_range(0, 1)), 1'b0);
        rst_n = 1'b1;
        step(1'b0, 1'b0);
        chk("rst_no_done", 32'(cap_done_n), 32'd0);
        clear_caps();
        send_frame(32'h5A0F80C3, ^32'h5A0F80C3, -1);
        step(1'b0, 1'b0);
        check_words("post_rst", 32'h5A0F80C3);
        chk("post_rst_perr", 32'(cap_perr), 32'd0);

        // Randomized frames with idle gaps, random parity and occasional spurious locks.
        for (int r = 0; r < 12; r++) begin
            rx = $urandom_range(0, 4);
            for (int g = 0; g < rx; g++) step(1'($urandom_range(0, 1)), 1'b0);
            rw   = $urandom;
            rbad = 1'($urandom_range(0, 1));
            rx   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, NBITS)) : -1;
            clear_caps();
            send_frame(rw, (^rw) ^ rbad, rx);
            step(1'b0, 1'b0);
            check_words("rand", rw);
            chk("rand_perr", 32'(cap_perr), 32'(rbad));
        end

        for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_bit_stream_deframer
